// File: rtl/regfile_writeback_arbiter.sv
// rtl/regfile_writeback_arbiter.sv - merges pipeline writeback and buffered long-latency results onto one regfile write port
module regfile_writeback_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_valid,
  input  logic [4:0]                    wb_rd,
  input  logic [XLEN-1:0]               wb_data,
  input  logic                          ll_valid,
  output logic                          ll_ready,
  input  logic [4:0]                    ll_rd,
  input  logic [XLEN-1:0]               ll_data,
  input  logic                          issue_valid,
  input  logic [4:0]                    issue_rd,
  output logic [31:0]                   busy_mask,
  output logic                          wb_stall,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          RegWrite,
  output logic [4:0]                    writeReg,
  output logic [XLEN-1:0]               writeData
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      rd_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] data_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [SW-1:0]   starve_cnt, starve_next;
  logic            from_ll, popped;
  logic            a_win, push, pop, fifo_empty;
  logic [31:0]     busy_next;

  assign fifo_empty = (fifo_count == '0);
  assign ll_ready   = rst_n && (fifo_count < CW'(FIFO_DEPTH));
  assign push       = ll_valid && ll_ready && (ll_rd != 5'd0);
  assign a_win      = wb_valid && (wb_rd != 5'd0);
  assign pop        = !a_win && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= ll_rd;
      data_mem[wr_ptr] <= ll_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      from_ll   <= 1'b0;
    end else if (a_win) begin
      RegWrite  <= 1'b1;
      writeReg  <= wb_rd;
      writeData <= wb_data;
      from_ll   <= 1'b0;
    end else if (pop) begin
      RegWrite  <= 1'b1;
      writeReg  <= rd_mem[rd_ptr];
      writeData <= data_mem[rd_ptr];
      from_ll   <= 1'b1;
    end else begin
      RegWrite  <= 1'b0;
      from_ll   <= 1'b0;
    end
  end

  // Clear lands on the commit edge of the long-latency result; a same-edge issue re-sets the bit.
  always_comb begin
    busy_next = busy_mask;
    if (RegWrite && from_ll) busy_next[writeReg] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) busy_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_mask <= '0;
    else        busy_mask <= busy_next;
  end

  always_comb begin
    starve_next = starve_cnt;
    if (pop || fifo_empty)
      starve_next = '0;
    else if (a_win && (starve_cnt != SW'(STARVE_LIMIT)))
      starve_next = starve_cnt + SW'(1);
  end

  // Stall drops one edge after the pop so the pipeline sees the freed slot before resuming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      popped     <= 1'b0;
      wb_stall   <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      popped     <= pop;
      wb_stall   <= (starve_next == SW'(STARVE_LIMIT)) || (wb_stall && !popped);
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb/tb_regfile_writeback_arbiter.sv - directed self-checking bench for regfile_writeback_arbiter
module tb_regfile_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, ll_valid, issue_valid;
  logic [4:0]  wb_rd, ll_rd, issue_rd;
  logic [31:0] wb_data, ll_data;
  logic        ll_ready, wb_stall, RegWrite;
  logic [31:0] busy_mask, writeData;
  logic [2:0]  fifo_count;
  logic [4:0]  writeReg;

  int tests  = 0;
  int failed = 0;

  regfile_writeback_arbiter #(.XLEN(32), .FIFO_DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busy_mask(busy_mask), .wb_stall(wb_stall), .fifo_count(fifo_count),
    .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; ll_valid = 0; issue_valid = 0;
    wb_rd = 0; ll_rd = 0; issue_rd = 0; wb_data = 0; ll_data = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #1;
    check("rst_regwrite", RegWrite, 0);
    check("rst_ll_ready", ll_ready, 0);
    check("rst_busy", busy_mask, 0);
    check("rst_count", fifo_count, 0);
    step(); step();
    rst_n = 1;
    #1;
    check("ready_after_rst", ll_ready, 1);

    // single pipeline writeback
    wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    step();
    check("wb_we", RegWrite, 1);
    check("wb_reg", writeReg, 5);
    check("wb_data", writeData, 32'hDEADBEEF);
    idle();
    step();
    check("wb_we_off", RegWrite, 0);
    check("wb_reg_hold", writeReg, 5);

    // pipeline wins over a queued entry, queued entry follows
    ll_valid = 1; ll_rd = 7; ll_data = 32'h11;
    step();
    check("q1_count", fifo_count, 1);
    check("q1_no_we", RegWrite, 0);
    idle(); wb_valid = 1; wb_rd = 3; wb_data = 32'h22;
    step();
    check("pri_reg", writeReg, 3);
    check("pri_data", writeData, 32'h22);
    check("pri_count", fifo_count, 1);
    idle();
    step();
    check("ll_we", RegWrite, 1);
    check("ll_reg", writeReg, 7);
    check("ll_data", writeData, 32'h11);
    check("ll_count0", fifo_count, 0);
    step();
    check("ll_we_off", RegWrite, 0);

    // fill FIFO under continuous writeback, then drain in order
    wb_valid = 1; wb_rd = 1; wb_data = 32'hAA; ll_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ll_rd = 5'(10 + i); ll_data = 32'h1000 + i;
      step();
    end
    check("full_count", fifo_count, 4);
    check("full_ready", ll_ready, 0);
    check("full_stall_pre", wb_stall, 0);
    ll_rd = 14; ll_data = 32'h1004;
    step();
    check("fifth_count", fifo_count, 4);
    check("fifth_ready", ll_ready, 0);
    check("starve_stall", wb_stall, 1);
    check("starve_wreg", writeReg, 1);
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_we", RegWrite, 1);
      check("drain_reg", writeReg, 5'(10 + i));
      check("drain_data", writeData, 32'h1000 + i);
      check("drain_count", fifo_count, 3 - i);
      if (i == 0) begin
        check("drain_ready", ll_ready, 1);
        check("stall_hold", wb_stall, 1);
      end
      if (i == 1) check("stall_clear", wb_stall, 0);
    end
    step();
    check("drain_done", RegWrite, 0);

    // scoreboard set and commit-coincident clear
    issue_valid = 1; issue_rd = 9;
    step();
    check("busy_set", busy_mask, 32'h200);
    idle(); ll_valid = 1; ll_rd = 9; ll_data = 32'h99;
    step();
    idle();
    step();
    check("busy_pop_reg", writeReg, 9);
    check("busy_before_commit", busy_mask, 32'h200);
    step();
    check("busy_cleared", busy_mask, 0);
    issue_valid = 1; issue_rd = 9;
    step();
    idle(); ll_valid = 1; ll_rd = 9; ll_data = 32'h98;
    step();
    idle();
    step();
    issue_valid = 1; issue_rd = 9;
    step();
    check("busy_set_wins", busy_mask, 32'h200);
    idle();

    // zero-destination offers are dropped
    wb_valid = 1; wb_rd = 0; wb_data = 32'h55; ll_valid = 1; ll_rd = 0; ll_data = 32'h66;
    #1;
    check("zero_ready", ll_ready, 1);
    step();
    check("zero_no_we", RegWrite, 0);
    check("zero_count", fifo_count, 0);

    // three queued entries plus busy bits, then asynchronous reset mid-cycle
    idle(); wb_valid = 1; wb_rd = 1; wb_data = 32'h1;
    ll_valid = 1; ll_rd = 20; ll_data = 32'h20; issue_valid = 1; issue_rd = 10;
    step();
    ll_rd = 21; ll_data = 32'h21; issue_rd = 11;
    step();
    ll_rd = 22; ll_data = 32'h22; issue_valid = 0;
    step();
    idle(); wb_valid = 1; wb_rd = 1;
    check("pre_rst_count", fifo_count, 3);
    check("pre_rst_busy", busy_mask, 32'h00000E00);
    #2 rst_n = 0;
    #1;
    check("arst_we", RegWrite, 0);
    check("arst_reg", writeReg, 0);
    check("arst_data", writeData, 0);
    check("arst_busy", busy_mask, 0);
    check("arst_count", fifo_count, 0);
    check("arst_stall", wb_stall, 0);
    check("arst_ready", ll_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
